// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-setting front end for an hh:mm:ss BCD counter chain
// Ports: i_clk/i_reset (async, active-high), i_tick 1 Hz enable,
//        i_btn_mode/i_btn_inc button pulses, i_hh/i_mm/i_ss counter readback;
//        o_ena count enable, o_wr_hh/o_wr_mm/o_wr_ss load strobes with o_wr_data,
//        o_blank per-field blanking {hh,mm,ss}, o_state current mode.
module clock_set_ctrl #(
    parameter logic [7:0] P_HR_MAX = 8'h23,
    parameter logic [7:0] P_MS_MAX = 8'h59
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic       i_btn_mode,
    input  logic       i_btn_inc,
    input  logic [7:0] i_hh,
    input  logic [7:0] i_mm,
    input  logic [7:0] i_ss,
    output logic       o_ena,
    output logic       o_wr_hh,
    output logic       o_wr_mm,
    output logic       o_wr_ss,
    output logic [7:0] o_wr_data,
    output logic [2:0] o_blank,
    output logic [1:0] o_state
);
    typedef enum logic [1:0] {RUN, SET_HH, SET_MM, SET_SS} state_t;
    state_t     state_q, state_d, state_nx;
    logic [7:0] edit_q, edit_d, wr_data_q, wr_data_d, fmax, succ;
    logic [2:0] blank_q, blank_d;
    logic       blink_q, blink_d, wr_hh_q, wr_hh_d, wr_mm_q, wr_mm_d, wr_ss_q, wr_ss_d;
    logic       inc, bad;
    always_comb begin
        state_nx  = state_t'(state_q + 2'd1);
        // mode wins over inc; inc is meaningless in RUN
        inc       = i_btn_inc & ~i_btn_mode & (state_q != RUN);
        fmax      = (state_q == SET_HH) ? P_HR_MAX : P_MS_MAX;
        bad       = (edit_q[7:4] > 4'd9) | (edit_q[3:0] > 4'd9);
        // seconds only clear; at/above max or non-BCD wraps to zero
        succ      = (state_q == SET_SS || bad || edit_q >= fmax) ? 8'h00 :
                    (edit_q[3:0] == 4'd9) ? {edit_q[7:4] + 4'd1, 4'd0} : edit_q + 8'd1;
        state_d   = i_btn_mode ? state_nx : state_q;
        edit_d    = !i_btn_mode ? (inc ? succ : edit_q) :
                    (state_nx == SET_HH) ? i_hh :
                    (state_nx == SET_MM) ? i_mm :
                    (state_nx == SET_SS) ? i_ss : edit_q;
        wr_hh_d   = inc & (state_q == SET_HH);
        wr_mm_d   = inc & (state_q == SET_MM);
        wr_ss_d   = inc & (state_q == SET_SS);
        wr_data_d = inc ? succ : wr_data_q;
        blink_d   = i_btn_mode ? 1'b0 : (i_tick && state_q != RUN) ? ~blink_q : blink_q;
        // blank tracks the next-cycle flag/state so it is never lit alongside a strobe
        blank_d   = (state_d == RUN || !blink_d || inc) ? 3'b000 :
                    (state_d == SET_HH) ? 3'b100 :
                    (state_d == SET_MM) ? 3'b010 : 3'b001;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= RUN;
            edit_q    <= 8'h00;
            blink_q   <= 1'b0;
            wr_hh_q   <= 1'b0;
            wr_mm_q   <= 1'b0;
            wr_ss_q   <= 1'b0;
            wr_data_q <= 8'h00;
            blank_q   <= 3'b000;
        end else begin
            state_q   <= state_d;
            edit_q    <= edit_d;
            blink_q   <= blink_d;
            wr_hh_q   <= wr_hh_d;
            wr_mm_q   <= wr_mm_d;
            wr_ss_q   <= wr_ss_d;
            wr_data_q <= wr_data_d;
            blank_q   <= blank_d;
        end
    end
    assign o_ena     = i_tick & (state_q == RUN) & ~i_reset;
    assign o_wr_hh   = wr_hh_q;
    assign o_wr_mm   = wr_mm_q;
    assign o_wr_ss   = wr_ss_q;
    assign o_wr_data = wr_data_q;
    assign o_blank   = blank_q;
    assign o_state   = state_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;
    logic       i_clk = 1'b0, i_reset = 1'b1, i_tick = 1'b0, i_btn_mode = 1'b0, i_btn_inc = 1'b0;
    logic [7:0] i_hh = 8'h00, i_mm = 8'h00, i_ss = 8'h00;
    logic       o_ena, o_wr_hh, o_wr_mm, o_wr_ss;
    logic [7:0] o_wr_data;
    logic [2:0] o_blank;
    logic [1:0] o_state;
    int         n_cmp = 0, n_err = 0;
    // {strobes hh/mm/ss, data, blank, state}
    wire [15:0] obs = {o_wr_hh, o_wr_mm, o_wr_ss, o_wr_data, o_blank, o_state};

    clock_set_ctrl dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick), .i_btn_mode(i_btn_mode),
        .i_btn_inc(i_btn_inc), .i_hh(i_hh), .i_mm(i_mm), .i_ss(i_ss), .o_ena(o_ena),
        .o_wr_hh(o_wr_hh), .o_wr_mm(o_wr_mm), .o_wr_ss(o_wr_ss), .o_wr_data(o_wr_data),
        .o_blank(o_blank), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic step(input logic m, input logic n, input logic t);
        @(negedge i_clk);
        i_btn_mode = m; i_btn_inc = n; i_tick = t;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset;
        i_tick = 1'b1;
        #3;
        n_cmp++; if (obs !== 16'h0000) begin n_err++; $display("FAIL reset_outs got %h want %h", obs, 16'h0000); end
        n_cmp++; if (o_ena !== 1'b0) begin n_err++; $display("FAIL reset_ena got %b want 0", o_ena); end
        @(negedge i_clk);
        i_reset = 1'b0; i_tick = 1'b0;
    endtask

    task automatic test_run;
        step(0, 0, 1);
        n_cmp++; if (o_ena !== 1'b1) begin n_err++; $display("FAIL run_ena got %b want 1", o_ena); end
        n_cmp++; if (obs !== 16'h0000) begin n_err++; $display("FAIL run_outs got %h want %h", obs, 16'h0000); end
        step(0, 1, 0);
        n_cmp++; if (o_ena !== 1'b0) begin n_err++; $display("FAIL run_ena_low got %b want 0", o_ena); end
        n_cmp++; if (obs !== 16'h0000) begin n_err++; $display("FAIL run_inc_ignored got %h want %h", obs, 16'h0000); end
    endtask

    task automatic test_set_hh;
        i_hh = 8'h22;
        step(1, 0, 0);
        n_cmp++; if (obs !== {3'b000, 8'h00, 3'b000, 2'd1}) begin n_err++; $display("FAIL hh_enter got %h want %h", obs, {3'b000, 8'h00, 3'b000, 2'd1}); end
        step(0, 1, 0);
        n_cmp++; if (obs !== {3'b100, 8'h23, 3'b000, 2'd1}) begin n_err++; $display("FAIL hh_inc1 got %h want %h", obs, {3'b100, 8'h23, 3'b000, 2'd1}); end
        step(0, 1, 0);
        n_cmp++; if (obs !== {3'b100, 8'h00, 3'b000, 2'd1}) begin n_err++; $display("FAIL hh_wrap got %h want %h", obs, {3'b100, 8'h00, 3'b000, 2'd1}); end
        step(0, 0, 1);
        n_cmp++; if (o_ena !== 1'b0) begin n_err++; $display("FAIL hh_ena got %b want 0", o_ena); end
        n_cmp++; if (obs !== {3'b000, 8'h00, 3'b100, 2'd1}) begin n_err++; $display("FAIL hh_blink_on got %h want %h", obs, {3'b000, 8'h00, 3'b100, 2'd1}); end
        step(0, 0, 1);
        n_cmp++; if (obs !== {3'b000, 8'h00, 3'b000, 2'd1}) begin n_err++; $display("FAIL hh_blink_off got %h want %h", obs, {3'b000, 8'h00, 3'b000, 2'd1}); end
    endtask

    task automatic test_set_mm;
        i_mm = 8'h09;
        step(1, 0, 0);
        n_cmp++; if (obs !== {3'b000, 8'h00, 3'b000, 2'd2}) begin n_err++; $display("FAIL mm_enter got %h want %h", obs, {3'b000, 8'h00, 3'b000, 2'd2}); end
        step(0, 1, 0);
        n_cmp++; if (obs !== {3'b010, 8'h10, 3'b000, 2'd2}) begin n_err++; $display("FAIL mm_carry got %h want %h", obs, {3'b010, 8'h10, 3'b000, 2'd2}); end
        step(0, 0, 0);
        n_cmp++; if (obs !== {3'b000, 8'h10, 3'b000, 2'd2}) begin n_err++; $display("FAIL mm_data_hold got %h want %h", obs, {3'b000, 8'h10, 3'b000, 2'd2}); end
    endtask

    task automatic test_set_ss;
        i_ss = 8'h47;
        step(1, 0, 1);
        n_cmp++; if (obs !== {3'b000, 8'h10, 3'b000, 2'd3}) begin n_err++; $display("FAIL ss_enter got %h want %h", obs, {3'b000, 8'h10, 3'b000, 2'd3}); end
        step(0, 1, 0);
        n_cmp++; if (obs !== {3'b001, 8'h00, 3'b000, 2'd3}) begin n_err++; $display("FAIL ss_clear got %h want %h", obs, {3'b001, 8'h00, 3'b000, 2'd3}); end
        step(1, 0, 0);
        n_cmp++; if (obs !== 16'h0000) begin n_err++; $display("FAIL ss_to_run got %h want %h", obs, 16'h0000); end
    endtask

    task automatic test_mode_inc;
        step(1, 0, 0);
        i_mm = 8'h6A;
        step(1, 0, 0);
        n_cmp++; if (obs !== {3'b000, 8'h00, 3'b000, 2'd2}) begin n_err++; $display("FAIL mi_enter_mm got %h want %h", obs, {3'b000, 8'h00, 3'b000, 2'd2}); end
        i_mm = 8'h09;
        step(0, 1, 0);
        n_cmp++; if (obs !== {3'b010, 8'h00, 3'b000, 2'd2}) begin n_err++; $display("FAIL mi_nonbcd got %h want %h", obs, {3'b010, 8'h00, 3'b000, 2'd2}); end
        step(1, 1, 0);
        n_cmp++; if (obs !== {3'b000, 8'h00, 3'b000, 2'd3}) begin n_err++; $display("FAIL mi_priority got %h want %h", obs, {3'b000, 8'h00, 3'b000, 2'd3}); end
        step(1, 0, 0);
        n_cmp++; if (obs !== 16'h0000) begin n_err++; $display("FAIL mi_to_run got %h want %h", obs, 16'h0000); end
    endtask

    task automatic test_reset_mid;
        i_hh = 8'h12;
        step(1, 0, 0);
        step(0, 0, 1);
        n_cmp++; if (obs !== {3'b000, 8'h00, 3'b100, 2'd1}) begin n_err++; $display("FAIL rm_tick1 got %h want %h", obs, {3'b000, 8'h00, 3'b100, 2'd1}); end
        step(0, 0, 1);
        step(0, 1, 0);
        n_cmp++; if (obs !== {3'b100, 8'h13, 3'b000, 2'd1}) begin n_err++; $display("FAIL rm_pre_write got %h want %h", obs, {3'b100, 8'h13, 3'b000, 2'd1}); end
        #1;
        i_reset = 1'b1; i_tick = 1'b1;
        #1;
        n_cmp++; if (obs !== 16'h0000) begin n_err++; $display("FAIL rm_async got %h want %h", obs, 16'h0000); end
        n_cmp++; if (o_ena !== 1'b0) begin n_err++; $display("FAIL rm_ena got %b want 0", o_ena); end
        @(negedge i_clk);
        i_reset = 1'b0; i_tick = 1'b0; i_btn_inc = 1'b0;
        @(posedge i_clk);
        #1;
        n_cmp++; if (obs !== 16'h0000) begin n_err++; $display("FAIL rm_resume got %h want %h", obs, 16'h0000); end
        step(0, 0, 1);
        n_cmp++; if (o_ena !== 1'b1) begin n_err++; $display("FAIL rm_run_ena got %b want 1", o_ena); end
    endtask

    initial begin
        test_reset;
        test_run;
        test_set_hh;
        test_set_mm;
        test_set_ss;
        test_mode_inc;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
